// File: rtl/zbritesi48_sekuencial.sv
// Two-cycle 48-bit subtractor: one shared 24-bit add-with-complement slice
// computes the low half, then the high half with the low-half borrow chained in.

module zbritesi48_slice #(
    parameter int HALF = 24
) (
    input  logic [HALF-1:0] x,
    input  logic [HALF-1:0] y,
    input  logic            bin,
    output logic [HALF-1:0] d,
    output logic            bout
);
    logic [HALF:0] sum;

    // x - y - bin computed as x + ~y + ~bin; carry-out low means a borrow occurred
    always_comb begin
        sum  = {1'b0, x} + {1'b0, ~y} + {{HALF{1'b0}}, ~bin};
        d    = sum[HALF-1:0];
        bout = ~sum[HALF];
    end
endmodule

module zbritesi48_sekuencial #(
    parameter int WIDTH = 48
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             Ready,
    output logic [WIDTH-1:0] Diferenca,
    output logic             BorrowOut,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow,
    output logic             Done
);
    localparam int HALF = WIDTH / 2;
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic [HALF-1:0]  dlo_q, dlo_d;
    logic [WIDTH-1:0] dif_q, dif_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             sel_hi;
    logic [HALF-1:0]  sl_x, sl_y, sl_d;
    logic             sl_bin, sl_bout;
    logic [WIDTH-1:0] res;

    // The single slice is steered to the high half only while in HIGH
    always_comb begin
        sel_hi = (state_q == HIGH);
        sl_x   = sel_hi ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
        sl_y   = sel_hi ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
        sl_bin = sel_hi ? borrow_q : bin_q;
    end

    zbritesi48_slice #(.HALF(HALF)) u_slice (
        .x    (sl_x),
        .y    (sl_y),
        .bin  (sl_bin),
        .d    (sl_d),
        .bout (sl_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        dlo_d    = dlo_q;
        dif_d    = dif_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        res      = {sl_d, dlo_q};
        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    bin_d   = BIN;
                    state_d = LOW;
                end
            end
            LOW: begin
                dlo_d    = sl_d;
                borrow_d = sl_bout;
                state_d  = HIGH;
            end
            HIGH: begin
                // Result and flags are committed together from the full new value
                dif_d   = res;
                bout_d  = sl_bout;
                zero_d  = (res == '0);
                neg_d   = res[MSB];
                ovf_d   = (a_q[MSB] != b_q[MSB]) && (res[MSB] != a_q[MSB]);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            dlo_q    <= '0;
            dif_q    <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            dlo_q    <= dlo_d;
            dif_q    <= dif_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign Ready     = (state_q == IDLE);
    assign Diferenca = dif_q;
    assign BorrowOut = bout_q;
    assign Zero      = zero_q;
    assign Negative  = neg_q;
    assign Overflow  = ovf_q;
    assign Done      = done_q;
endmodule
